// File: rtl/riscorvo_mtimer.sv
// Machine timer (mtime/mtimecmp/prescaler) on a valid/ready word bus; ready pulses one cycle after accept.
// No backpressure: hits are accepted in IDLE only, requests presented during ACK are not sampled.
module riscorvo_mtimer #(
  parameter logic [31:0] MTIME_ADDR     = 32'hA000_0000,
  parameter logic [31:0] MTIMEH_ADDR    = 32'hA000_0004,
  parameter logic [31:0] MTIMECMP_ADDR  = 32'hA000_0008,
  parameter logic [31:0] MTIMECMPH_ADDR = 32'hA000_000C,
  parameter logic [31:0] MTIMEDIV_ADDR  = 32'hA000_0010
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_data_i,
  output logic        ready_data_o,
  input  logic [31:0] addr_data_i,
  input  logic [31:0] write_data_i,
  input  logic        read_write_i,
  input  logic [3:0]  mask_data_i,
  output logic [31:0] read_data_o,
  output logic        hit_o,
  output logic        timer_irq_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACK  = 1'b1;

  logic [0:0]  state;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [31:0] mtimediv;
  logic [31:0] presc_cnt;

  logic [63:0] mtime_nxt;
  logic [63:0] mtimecmp_nxt;
  logic [31:0] mtimediv_nxt;
  logic [31:0] presc_nxt;
  logic [31:0] rd_val;

  logic sel_time, sel_timeh, sel_cmp, sel_cmph, sel_div;
  logic accept, wr_en, tick;
  logic unused_addr_bits;

  // Word decode only; the byte offset is irrelevant for 32-bit registers.
  assign sel_time  = (addr_data_i[31:2] == MTIME_ADDR[31:2]);
  assign sel_timeh = (addr_data_i[31:2] == MTIMEH_ADDR[31:2]);
  assign sel_cmp   = (addr_data_i[31:2] == MTIMECMP_ADDR[31:2]);
  assign sel_cmph  = (addr_data_i[31:2] == MTIMECMPH_ADDR[31:2]);
  assign sel_div   = (addr_data_i[31:2] == MTIMEDIV_ADDR[31:2]);
  assign unused_addr_bits = ^addr_data_i[1:0];

  assign hit_o        = sel_time | sel_timeh | sel_cmp | sel_cmph | sel_div;
  assign accept       = (state == IDLE) && valid_data_i && hit_o;
  assign wr_en        = accept && read_write_i;
  assign ready_data_o = (state == ACK);
  assign tick         = (presc_cnt == mtimediv);

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  always_comb begin
    mtime_nxt    = tick ? (mtime + 64'd1) : mtime;
    mtimecmp_nxt = mtimecmp;
    mtimediv_nxt = mtimediv;
    presc_nxt    = tick ? 32'd0 : (presc_cnt + 32'd1);
    // A write to either mtime half replaces the increment; the other half keeps its old value.
    if (wr_en) begin
      if (sel_time) begin
        mtime_nxt = {mtime[63:32], merge_bytes(mtime[31:0], write_data_i, mask_data_i)};
      end else if (sel_timeh) begin
        mtime_nxt = {merge_bytes(mtime[63:32], write_data_i, mask_data_i), mtime[31:0]};
      end else if (sel_cmp) begin
        mtimecmp_nxt[31:0] = merge_bytes(mtimecmp[31:0], write_data_i, mask_data_i);
      end else if (sel_cmph) begin
        mtimecmp_nxt[63:32] = merge_bytes(mtimecmp[63:32], write_data_i, mask_data_i);
      end else if (sel_div) begin
        mtimediv_nxt = merge_bytes(mtimediv, write_data_i, mask_data_i);
        presc_nxt    = 32'd0;
      end
    end
  end

  always_comb begin
    rd_val = 32'd0;
    if (sel_time)       rd_val = mtime[31:0];
    else if (sel_timeh) rd_val = mtime[63:32];
    else if (sel_cmp)   rd_val = mtimecmp[31:0];
    else if (sel_cmph)  rd_val = mtimecmp[63:32];
    else if (sel_div)   rd_val = mtimediv;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      read_data_o <= 32'd0;
      timer_irq_o <= 1'b0;
      mtime       <= 64'd0;
      mtimecmp    <= 64'hFFFF_FFFF_FFFF_FFFF;
      mtimediv    <= 32'd0;
      presc_cnt   <= 32'd0;
    end else begin
      state       <= accept ? ACK : IDLE;
      if (accept) read_data_o <= read_write_i ? 32'd0 : rd_val;
      mtime       <= mtime_nxt;
      mtimecmp    <= mtimecmp_nxt;
      mtimediv    <= mtimediv_nxt;
      presc_cnt   <= presc_nxt;
      timer_irq_o <= (mtime_nxt >= mtimecmp_nxt);
    end
  end

endmodule

// File: tb/tb_riscorvo_mtimer.sv
// Randomized scoreboard bench for riscorvo_mtimer against a tick-counting reference model.
module tb_riscorvo_mtimer;

  localparam logic [31:0] BASE = 32'hA000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_data_i;
  logic        ready_data_o;
  logic [31:0] addr_data_i;
  logic [31:0] write_data_i;
  logic        read_write_i;
  logic [3:0]  mask_data_i;
  logic [31:0] read_data_o;
  logic        hit_o;
  logic        timer_irq_o;

  always #5 clk = ~clk;

  riscorvo_mtimer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .valid_data_i (valid_data_i),
    .ready_data_o (ready_data_o),
    .addr_data_i  (addr_data_i),
    .write_data_i (write_data_i),
    .read_write_i (read_write_i),
    .mask_data_i  (mask_data_i),
    .read_data_o  (read_data_o),
    .hit_o        (hit_o),
    .timer_irq_o  (timer_irq_o)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] rd_q[$];
  logic        irq_q[$];
  bit          irq_en = 1'b0;
  longint      cyc;

  // Model: mtime = base + ticks since the counter anchor, counted from the mtime anchor.
  logic [63:0] m_base;
  logic [63:0] m_cmp;
  logic [31:0] m_div;
  longint      m_mt_anc;
  longint      m_cnt_anc;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] m_time(input longint e);
    logic [63:0] d1, k, k0;
    d1 = {32'd0, m_div} + 64'd1;
    k  = 64'(e - m_cnt_anc);
    k0 = 64'(m_mt_anc - m_cnt_anc);
    return m_base + k / d1 - k0 / d1;
  endfunction

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    cyc = 0; m_base = 64'd0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_div = 32'd0;
    m_mt_anc = 0; m_cnt_anc = 0;
  endtask

  function automatic logic [31:0] model_read(input int idx);
    logic [63:0] t;
    t = m_time(cyc);
    case (idx)
      0:       return t[31:0];
      1:       return t[63:32];
      2:       return m_cmp[31:0];
      3:       return m_cmp[63:32];
      default: return m_div;
    endcase
  endfunction

  // Applies a write landing on edge cyc+1.
  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] m);
    logic [63:0] t;
    case (idx)
      0: begin t = m_time(cyc); m_base = {t[63:32], mrg(t[31:0], d, m)}; m_mt_anc = cyc + 1; end
      1: begin t = m_time(cyc); m_base = {mrg(t[63:32], d, m), t[31:0]}; m_mt_anc = cyc + 1; end
      2: m_cmp[31:0]  = mrg(m_cmp[31:0], d, m);
      3: m_cmp[63:32] = mrg(m_cmp[63:32], d, m);
      default: begin
        t = m_time(cyc + 1);
        m_div = mrg(m_div, d, m);
        m_base = t; m_mt_anc = cyc + 1; m_cnt_anc = cyc + 1;
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (irq_en) irq_q.push_back(m_time(cyc) >= m_cmp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic req(input int idx, input bit rw, input logic [31:0] d, input logic [3:0] m);
    addr_data_i  = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
    read_write_i = rw;
    write_data_i = d;
    mask_data_i  = m;
    valid_data_i = 1'b1;
    #1 check("hit_valid_reg", hit_o, 1);
    rd_q.push_back(rw ? 32'd0 : model_read(idx));
    if (rw) model_write(idx, d, m);
    tick();
    valid_data_i = 1'b0;
    tick();
  endtask

  task automatic miss(input logic [31:0] a, input int hold);
    addr_data_i  = a;
    read_write_i = $urandom_range(0, 1);
    write_data_i = $urandom;
    mask_data_i  = 4'hF;
    valid_data_i = 1'b1;
    for (int i = 0; i < hold; i++) begin
      #1 check("hit_miss", hit_o, 0);
      tick();
    end
    valid_data_i = 1'b0;
  endtask

  logic [31:0] mon_exp;
  always @(negedge clk) begin
    if (reset_n && ready_data_o) begin
      if (rd_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_ready: got ready=1 expected 0 (t=%0t)", $time);
      end else begin
        mon_exp = rd_q.pop_front();
        check("read_data", read_data_o, mon_exp);
      end
    end
    if (irq_q.size() != 0) check("timer_irq", timer_irq_o, irq_q.pop_front());
  end

  initial begin
    reset_n = 1'b0; valid_data_i = 1'b0; addr_data_i = 32'd0;
    write_data_i = 32'd0; read_write_i = 1'b0; mask_data_i = 4'h0;
    #1;
    check("rst_ready", ready_data_o, 0);
    check("rst_rdata", read_data_o, 0);
    check("rst_irq", timer_irq_o, 0);
    check("rst_hit_addr0", hit_o, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    irq_en = 1'b1;

    // First read after reset sees mtime = 5 with divisor 0.
    idle(5);
    req(0, 1'b0, 32'd0, 4'h0);

    // Divisor 3: two increments per eight cycles.
    req(4, 1'b1, 32'd3, 4'hF);
    req(0, 1'b0, 32'd0, 4'h0);
    idle(8);
    req(0, 1'b0, 32'd0, 4'h0);
    req(4, 1'b0, 32'd0, 4'h0);

    // Compare-match interrupt rise and fall.
    req(4, 1'b1, 32'd0, 4'hF);
    req(0, 1'b1, 32'd0, 4'hF);
    req(1, 1'b1, 32'd0, 4'hF);
    req(2, 1'b1, 32'd20, 4'hF);
    req(3, 1'b1, 32'd0, 4'hF);
    idle(25);
    req(2, 1'b1, 32'hFFFF_FFFF, 4'hF);
    idle(3);

    // Carry from low to high word.
    req(3, 1'b1, 32'hFFFF_FFFF, 4'hF);
    req(0, 1'b1, 32'hFFFF_FFFF, 4'hF);
    req(1, 1'b1, 32'd0, 4'hF);
    idle(2);
    req(1, 1'b0, 32'd0, 4'h0);
    req(0, 1'b0, 32'd0, 4'h0);

    // Byte-masked compare write.
    req(2, 1'b1, 32'h0000_AB00, 4'b0010);
    req(2, 1'b0, 32'd0, 4'h0);

    // Non-matching address held for several cycles.
    miss(BASE + 32'h14, 4);
    idle(2);

    // Valid held through ACK: second acceptance only after returning to IDLE.
    addr_data_i = BASE; read_write_i = 1'b0; mask_data_i = 4'h0; valid_data_i = 1'b1;
    rd_q.push_back(model_read(0));
    tick();
    tick();
    rd_q.push_back(model_read(0));
    tick();
    valid_data_i = 1'b0;
    tick();

    // Random traffic.
    for (int n = 0; n < 150; n++) begin
      int idx;
      idx = $urandom_range(0, 5);
      if (idx == 5) begin
        miss(($urandom_range(0, 1) == 1) ? (BASE + 32'h14 + 32'($urandom_range(0, 20) * 4))
                                         : (BASE ^ 32'h0100_0000), 1);
      end else if (idx == 4) begin
        if ($urandom_range(0, 1) == 1) req(4, 1'b1, 32'($urandom_range(0, 5)), 4'hF);
        else req(4, 1'b0, 32'd0, 4'h0);
      end else begin
        req(idx, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
      end
      idle($urandom_range(0, 3));
    end

    // Reset during ACK aborts the ready pulse.
    irq_en = 1'b0;
    tick();
    addr_data_i = BASE + 32'h8; read_write_i = 1'b0; mask_data_i = 4'h0; valid_data_i = 1'b1;
    mon_exp = model_read(2);
    @(posedge clk);
    #1;
    valid_data_i = 1'b0;
    check("ack_ready", ready_data_o, 1);
    check("ack_rdata", read_data_o, mon_exp);
    #1 reset_n = 1'b0;
    #1;
    check("abort_ready", ready_data_o, 0);
    check("abort_rdata", read_data_o, 0);
    check("abort_irq", timer_irq_o, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    irq_en = 1'b1;

    // Register state after the second reset.
    req(2, 1'b0, 32'd0, 4'h0);
    req(3, 1'b0, 32'd0, 4'h0);
    req(4, 1'b0, 32'd0, 4'h0);
    req(0, 1'b0, 32'd0, 4'h0);
    idle(3);

    check("rd_queue_drained", 64'(rd_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
